// File: rtl/bb_gpio_in_ctrl_if.sv
// Pad/config/status bundle between the GPIO input front end and its client.
// slave = front end, master = core logic driving config and reading events.
interface bb_gpio_in_ctrl_if #(parameter int N_CH = 8);
  logic [N_CH-1:0] bb_gpio_in;
  logic [N_CH-1:0] cfg_rise_en;
  logic [N_CH-1:0] cfg_fall_en;
  logic [N_CH-1:0] irq_mask;
  logic [N_CH-1:0] irq_clr;
  logic [N_CH-1:0] gpio_level;
  logic [N_CH-1:0] gpio_rise;
  logic [N_CH-1:0] gpio_fall;
  logic [N_CH-1:0] irq_status;
  logic            irq;

  modport master (
    output bb_gpio_in, cfg_rise_en, cfg_fall_en, irq_mask, irq_clr,
    input  gpio_level, gpio_rise, gpio_fall, irq_status, irq
  );

  modport slave (
    input  bb_gpio_in, cfg_rise_en, cfg_fall_en, irq_mask, irq_clr,
    output gpio_level, gpio_rise, gpio_fall, irq_status, irq
  );
endinterface

// File: rtl/bb_gpio_in_ctrl.sv
// GPIO input front end: per-channel synchroniser, debounce, edge pulses and
// sticky interrupt status; one lane instance per channel.
module bb_gpio_in_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic rise_en,
  input  logic fall_en,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic status
);
  localparam int             CW      = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   status_q, status_d;
  logic                   s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pad};
    s       = sync_q[SYNC_STAGES-1];
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any sample agreeing with the current level restarts the count.
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = s;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Set beats clear when both land in the same cycle.
    if ((rise_q & rise_en) | (fall_q & fall_en)) status_d = 1'b1;
    else if (clr)                                status_d = 1'b0;
    else                                         status_d = status_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign status = status_q;
endmodule

module bb_gpio_in_ctrl #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic                bb_clk_in,
  input  logic                bb_rst_in,
  bb_gpio_in_ctrl_if.slave    bus
);
  logic [N_CH-1:0] level, rise, fall, status;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    bb_gpio_in_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_lane (
      .clk     (bb_clk_in),
      .rst     (bb_rst_in),
      .pad     (bus.bb_gpio_in[i]),
      .rise_en (bus.cfg_rise_en[i]),
      .fall_en (bus.cfg_fall_en[i]),
      .clr     (bus.irq_clr[i]),
      .level   (level[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .status  (status[i])
    );
  end

  assign bus.gpio_level = level;
  assign bus.gpio_rise  = rise;
  assign bus.gpio_fall  = fall;
  assign bus.irq_status = status;
  assign bus.irq        = |(status & bus.irq_mask);
endmodule

// File: tb/tb_bb_gpio_in_ctrl.sv
// Directed scenarios plus randomized traffic, checked against a behavioural
// model built from delayed pad samples and run-length counting.
module tb_bb_gpio_in_ctrl;
  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #100 clk = ~clk;

  bb_gpio_in_ctrl_if #(.N_CH(N)) bus ();

  bb_gpio_in_ctrl #(.N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
    .bb_clk_in (clk),
    .bb_rst_in (rst),
    .bus       (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model: pad values seen at the last SYNC edges, newest first
  logic [N-1:0] m_hist [SYNC];
  int           m_run  [N];
  logic [N-1:0] m_level, m_rise, m_fall, m_status;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_hist[j] = '0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
    m_level = '0; m_rise = '0; m_fall = '0; m_status = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] s, set;
    if (rst) begin
      model_reset();
      return;
    end
    set      = (m_rise & bus.cfg_rise_en) | (m_fall & bus.cfg_fall_en);
    m_status = set | (m_status & ~bus.irq_clr);
    s        = m_hist[SYNC-1];
    m_rise   = '0;
    m_fall   = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = (s[c] == m_level[c]) ? 0 : m_run[c] + 1;
      if (m_run[c] == DB) begin
        m_run[c]   = 0;
        m_level[c] = s[c];
        if (s[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
      end
    end
    for (int j = SYNC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = bus.bb_gpio_in;
  endtask

  task automatic check_all();
    chk("level",  32'(bus.gpio_level), 32'(m_level));
    chk("rise",   32'(bus.gpio_rise),  32'(m_rise));
    chk("fall",   32'(bus.gpio_fall),  32'(m_fall));
    chk("status", 32'(bus.irq_status), 32'(m_status));
    chk("irq",    32'(bus.irq),        32'(|(m_status & bus.irq_mask)));
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    model_reset();
    bus.bb_gpio_in  = '0;
    bus.cfg_rise_en = '0;
    bus.cfg_fall_en = '0;
    bus.irq_mask    = '0;
    bus.irq_clr     = '0;
    tick(2);
    chk("reset_level",  32'(bus.gpio_level), 0);
    chk("reset_status", 32'(bus.irq_status), 0);
    chk("reset_irq",    32'(bus.irq), 0);
    rst = 1'b0;
    tick(2);

    // 1: rise on ch0 appears 5 edges after the capturing edge
    bus.bb_gpio_in = 8'h01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_no_early_rise", 32'(bus.gpio_rise), 0);
    end
    tick();
    chk("t1_rise",  32'(bus.gpio_rise),  32'h01);
    chk("t1_level", 32'(bus.gpio_level), 32'h01);
    tick();
    chk("t1_rise_one_cycle", 32'(bus.gpio_rise), 0);

    // 2: 3-cycle glitch on ch3 is filtered
    bus.bb_gpio_in = 8'h09;
    tick(3);
    bus.bb_gpio_in = 8'h01;
    tick(10);
    chk("t2_level",  32'(bus.gpio_level), 32'h01);
    chk("t2_status", 32'(bus.irq_status), 0);

    // 3: rise enabled, fall not; then clear
    bus.cfg_rise_en = 8'h01;
    bus.irq_mask    = 8'h01;
    bus.bb_gpio_in  = 8'h00;
    tick(8);
    chk("t3_fall_no_status", 32'(bus.irq_status), 0);
    bus.bb_gpio_in = 8'h01;
    tick(8);
    chk("t3_status", 32'(bus.irq_status), 32'h01);
    chk("t3_irq",    32'(bus.irq), 1);
    bus.bb_gpio_in = 8'h00;
    tick(8);
    chk("t3_fall_adds_nothing", 32'(bus.irq_status), 32'h01);
    bus.irq_clr = 8'h01;
    tick();
    bus.irq_clr = 8'h00;
    chk("t3_cleared", 32'(bus.irq_status), 0);
    chk("t3_irq_low", 32'(bus.irq), 0);

    // 4: clear coincident with an enabled rise pulse -> set wins
    bus.bb_gpio_in = 8'h01;
    tick(6);
    chk("t4_pulse", 32'(bus.gpio_rise), 32'h01);
    bus.irq_clr = 8'h01;
    tick();
    bus.irq_clr = 8'h00;
    chk("t4_set_wins", 32'(bus.irq_status), 32'h01);
    bus.irq_clr = 8'h01;
    tick();
    bus.irq_clr = 8'h00;

    // 5: mask gates only irq, combinationally
    bus.irq_mask    = 8'h00;
    bus.cfg_rise_en = 8'h04;
    bus.bb_gpio_in  = 8'h05;
    tick(8);
    chk("t5_status", 32'(bus.irq_status), 32'h04);
    chk("t5_irq_masked", 32'(bus.irq), 0);
    bus.irq_mask = 8'h04;
    #1;
    chk("t5_irq_unmasked", 32'(bus.irq), 1);

    // 6: reset mid-debounce, rise seen 6 edges after release
    bus.bb_gpio_in = 8'h07;
    tick(4);
    rst = 1'b1;
    tick();
    chk("t6_rst_level",  32'(bus.gpio_level), 0);
    chk("t6_rst_status", 32'(bus.irq_status), 0);
    chk("t6_rst_irq",    32'(bus.irq), 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_no_early_rise", 32'(bus.gpio_rise), 0);
    end
    tick();
    chk("t6_rise", 32'(bus.gpio_rise), 32'h07);

    // randomized traffic with held levels, glitches, config churn and resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) bus.bb_gpio_in = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) bus.bb_gpio_in ^= 8'(1 << $urandom_range(0, N-1));
      if ($urandom_range(0, 49) == 0) begin
        bus.cfg_rise_en = 8'($urandom);
        bus.cfg_fall_en = 8'($urandom);
        bus.irq_mask    = 8'($urandom);
      end
      bus.irq_clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.irq_clr = '0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
